// File: rtl/midi_msg_rx_if.sv
// Bundle of the MIDI receiver's serial input and message/real-time outputs.
// The receiver is the master; the voice/control logic is the slave.
interface midi_msg_rx_if;
  logic       serial;
  logic [7:0] msg_status;
  logic [7:0] msg_data1;
  logic [7:0] msg_data2;
  logic [1:0] msg_len;
  logic       msg_valid;
  logic [7:0] rt_byte;
  logic       rt_valid;
  logic       frame_err;

  modport master (
    input  serial,
    output msg_status, msg_data1, msg_data2, msg_len, msg_valid,
    output rt_byte, rt_valid, frame_err
  );

  modport slave (
    output serial,
    input  msg_status, msg_data1, msg_data2, msg_len, msg_valid,
    input  rt_byte, rt_valid, frame_err
  );
endinterface

// File: rtl/midi_msg_rx.sv
// MIDI receiver: 8N1 UART byte deserialiser feeding a message assembler with
// running status, real-time passthrough and framing-error detection.
module midi_msg_rx #(
  parameter int CLKS_PER_BIT   = 1600,
  parameter int SYNC_STAGES    = 2,
  parameter int RUNNING_STATUS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  midi_msg_rx_if.master m_if
);
  localparam int        CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam bit        RS_EN   = (RUNNING_STATUS != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_idx;
  logic [7:0]             r_shift;
  logic                   r_frame_err;

  logic [7:0] r_status;
  logic       r_need2;
  logic       r_dcnt;
  logic [7:0] r_d1;
  logic [7:0] r_msg_status;
  logic [7:0] r_msg_data1;
  logic [7:0] r_msg_data2;
  logic [1:0] r_msg_len;
  logic       r_msg_valid;
  logic [7:0] r_rt_byte;
  logic       r_rt_valid;

  logic       w_sr;
  logic       w_byte_done;
  logic [7:0] w_byte;

  assign w_sr        = r_sync[SYNC_STAGES-1];
  // A byte is complete in the stop-sample cycle itself, so the assembler
  // registers its result on the same edge that closes the byte.
  assign w_byte_done = (r_state == S_STOP) && (r_cnt == CNT_LAST) && w_sr;
  assign w_byte      = r_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{1'b1}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], m_if.serial};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_shift     <= 8'h00;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_sr) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
            r_state <= w_sr ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_sr;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (w_sr) begin
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // A held-low line stays here so it reports only one framing error.
        S_BREAK: begin
          if (w_sr) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_status     <= 8'h00;
      r_need2      <= 1'b0;
      r_dcnt       <= 1'b0;
      r_d1         <= 8'h00;
      r_msg_status <= 8'h00;
      r_msg_data1  <= 8'h00;
      r_msg_data2  <= 8'h00;
      r_msg_len    <= 2'd0;
      r_msg_valid  <= 1'b0;
      r_rt_byte    <= 8'h00;
      r_rt_valid   <= 1'b0;
    end else begin
      r_msg_valid <= 1'b0;
      r_rt_valid  <= 1'b0;
      if (w_byte_done) begin
        if (w_byte[7:3] == 5'b11111) begin
          r_rt_byte  <= w_byte;
          r_rt_valid <= 1'b1;
        end else if (w_byte[7] && (w_byte[7:4] != 4'hF)) begin
          r_status <= w_byte;
          r_dcnt   <= 1'b0;
          r_need2  <= (w_byte[7:5] != 3'b110);
        end else if (w_byte[7]) begin
          r_dcnt <= 1'b0;
          case (w_byte[3:0])
            4'h1, 4'h3: begin
              r_status <= w_byte;
              r_need2  <= 1'b0;
            end
            4'h2: begin
              r_status <= w_byte;
              r_need2  <= 1'b1;
            end
            default: begin
              r_msg_status <= w_byte;
              r_msg_data1  <= 8'h00;
              r_msg_data2  <= 8'h00;
              r_msg_len    <= 2'd1;
              r_msg_valid  <= 1'b1;
              r_status     <= 8'h00;
            end
          endcase
        end else if (r_status[7]) begin
          if (r_need2 && !r_dcnt) begin
            r_d1   <= w_byte;
            r_dcnt <= 1'b1;
          end else begin
            r_msg_status <= r_status;
            r_msg_data1  <= r_need2 ? r_d1 : w_byte;
            r_msg_data2  <= r_need2 ? w_byte : 8'h00;
            r_msg_len    <= r_need2 ? 2'd3 : 2'd2;
            r_msg_valid  <= 1'b1;
            r_dcnt       <= 1'b0;
            if (!(RS_EN && (r_status[7:4] != 4'hF))) begin
              r_status <= 8'h00;
            end
          end
        end
      end
    end
  end

  assign m_if.msg_status = r_msg_status;
  assign m_if.msg_data1  = r_msg_data1;
  assign m_if.msg_data2  = r_msg_data2;
  assign m_if.msg_len    = r_msg_len;
  assign m_if.msg_valid  = r_msg_valid;
  assign m_if.rt_byte    = r_rt_byte;
  assign m_if.rt_valid   = r_rt_valid;
  assign m_if.frame_err  = r_frame_err;
endmodule

// File: tb/tb_midi_msg_rx.sv
// Scoreboard bench for midi_msg_rx: one instance with running status and one
// without share the serial line; expected outputs are queued per instance.
module tb_midi_msg_rx;
  localparam int CPB = 16;
  // start edge -> 2 sync flops + IDLE detect + half bit + 9 full bits
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic serial = 1'b1;
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;

  typedef struct {
    int         kind;   // 1 msg, 2 real-time, 3 frame error
    logic [7:0] f1, f2, f3;
    logic [1:0] len;
    int         due;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         ka, kb;
    logic [7:0] s, d1, d2;
    logic [1:0] len;
  } tx_t;

  exp_t expq[2][$];
  tx_t  txq[$];

  midi_msg_rx_if if_a ();
  midi_msg_rx_if if_b ();
  assign if_a.serial = serial;
  assign if_b.serial = serial;

  midi_msg_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2), .RUNNING_STATUS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .m_if(if_a.master));
  midi_msg_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2), .RUNNING_STATUS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .m_if(if_b.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got still running, required finished");
    $fatal(1);
  end

  function automatic int kind_of(input logic mv, input logic rv, input logic fe);
    int n;
    n = int'(mv) + int'(rv) + int'(fe);
    if (n > 1) return 7;
    if (mv) return 1;
    if (rv) return 2;
    if (fe) return 3;
    return 0;
  endfunction

  task automatic add(input logic [7:0] b, input logic stop, input int ka, input int kb,
                     input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2,
                     input logic [1:0] len);
    tx_t t;
    t.b = b; t.stop = stop; t.ka = ka; t.kb = kb;
    t.s = s; t.d1 = d1; t.d2 = d2; t.len = len;
    txq.push_back(t);
  endtask

  task automatic drive_all();
    tx_t  t;
    exp_t e;
    while (txq.size() > 0) begin
      t = txq.pop_front();
      @(posedge clk); #1;
      serial = 1'b0;
      e.f1 = t.s; e.f2 = t.d1; e.f3 = t.d2; e.len = t.len; e.due = cyc + LAT;
      if (t.ka != 0) begin e.kind = t.ka; expq[0].push_back(e); end
      if (t.kb != 0) begin e.kind = t.kb; expq[1].push_back(e); end
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk); #1;
        serial = t.b[i];
      end
      repeat (CPB) @(posedge clk); #1;
      serial = t.stop;
      repeat (CPB) @(posedge clk); #1;
      serial = 1'b1;
    end
  endtask

  task automatic watch(input int ncyc);
    logic       mv[2], rv[2], fe[2];
    logic [7:0] st[2], d1[2], d2[2], rb[2];
    logic [1:0] ln[2];
    logic [25:0] ow, ew;
    exp_t e;
    int   k;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      mv[0] = if_a.msg_valid; rv[0] = if_a.rt_valid; fe[0] = if_a.frame_err;
      st[0] = if_a.msg_status; d1[0] = if_a.msg_data1; d2[0] = if_a.msg_data2;
      ln[0] = if_a.msg_len; rb[0] = if_a.rt_byte;
      mv[1] = if_b.msg_valid; rv[1] = if_b.rt_valid; fe[1] = if_b.frame_err;
      st[1] = if_b.msg_status; d1[1] = if_b.msg_data1; d2[1] = if_b.msg_data2;
      ln[1] = if_b.msg_len; rb[1] = if_b.rt_byte;
      for (int d = 0; d < 2; d++) begin
        k  = kind_of(mv[d], rv[d], fe[d]);
        ow = (k == 1) ? {st[d], d1[d], d2[d], ln[d]} :
             (k == 2) ? {rb[d], 18'd0} : 26'd0;
        if (k != 0) begin
          total++;
          if (expq[d].size() == 0) begin
            bad++;
            $display("FAIL unexpected_output dut%0d cyc=%0d: got kind=%0d word=%h, required none",
                     d, cyc, k, ow);
          end else begin
            e  = expq[d].pop_front();
            ew = {e.f1, e.f2, e.f3, e.len};
            if (k !== e.kind || ow !== ew || cyc !== e.due) begin
              bad++;
              $display("FAIL scoreboard dut%0d: got kind=%0d word=%h cyc=%0d, required kind=%0d word=%h cyc=%0d",
                       d, k, ow, cyc, e.kind, ew, e.due);
            end
          end
        end else if (expq[d].size() != 0 && cyc > expq[d][0].due) begin
          total++;
          bad++;
          e = expq[d].pop_front();
          $display("FAIL missing_output dut%0d: got nothing by cyc=%0d, required kind=%0d at cyc=%0d",
                   d, cyc, e.kind, e.due);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (expq[d].size() != 0) begin
        bad++;
        $display("FAIL leftover dut%0d: got %0d pending, required 0", d, expq[d].size());
        expq[d].delete();
      end
    end
  endtask

  task automatic run_seq();
    int n;
    n = txq.size();
    fork
      drive_all();
      watch(n * (CPB * 10 + 1) + 40);
    join
  endtask

  task automatic check_zero(input string name);
    logic [36:0] va, vb;
    @(negedge clk);
    va = {if_a.msg_status, if_a.msg_data1, if_a.msg_data2, if_a.msg_len, if_a.msg_valid,
          if_a.rt_byte, if_a.rt_valid, if_a.frame_err};
    vb = {if_b.msg_status, if_b.msg_data1, if_b.msg_data2, if_b.msg_len, if_b.msg_valid,
          if_b.rt_byte, if_b.rt_valid, if_b.frame_err};
    total++;
    if (va !== 37'd0) begin
      bad++;
      $display("FAIL %s dut0: got outputs=%h, required 0", name, va);
    end
    total++;
    if (vb !== 37'd0) begin
      bad++;
      $display("FAIL %s dut1: got outputs=%h, required 0", name, vb);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    check_zero("reset_values");
    @(posedge clk); #1;
    rst_n = 1'b1;
    watch(40);
  endtask

  task automatic test_basic();
    add(8'h90, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h3C, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h64, 1'b1, 1, 1, 8'h90, 8'h3C, 8'h64, 2'd3);
    run_seq();
  endtask

  task automatic test_running_status();
    add(8'h90, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h3C, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h64, 1'b1, 1, 1, 8'h90, 8'h3C, 8'h64, 2'd3);
    add(8'h3E, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h00, 1'b1, 1, 0, 8'h90, 8'h3E, 8'h00, 2'd3);
    run_seq();
  endtask

  task automatic test_short_msgs();
    add(8'hC5, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h07, 1'b1, 1, 1, 8'hC5, 8'h07, 8'h00, 2'd2);
    add(8'hF6, 1'b1, 1, 1, 8'hF6, 8'h00, 8'h00, 2'd1);
    run_seq();
  endtask

  task automatic test_system_common();
    add(8'hF2, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h01, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h02, 1'b1, 1, 1, 8'hF2, 8'h01, 8'h02, 2'd3);
    add(8'h03, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'hF0, 1'b1, 1, 1, 8'hF0, 8'h00, 8'h00, 2'd1);
    add(8'h11, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'hF7, 1'b1, 1, 1, 8'hF7, 8'h00, 8'h00, 2'd1);
    run_seq();
  endtask

  task automatic test_realtime();
    add(8'h90, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h3C, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'hF8, 1'b1, 2, 2, 8'hF8, 8'h00, 8'h00, 2'd0);
    add(8'h64, 1'b1, 1, 1, 8'h90, 8'h3C, 8'h64, 2'd3);
    run_seq();
  endtask

  task automatic test_frame_err();
    add(8'h3C, 1'b0, 3, 3, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h90, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h3C, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h64, 1'b1, 1, 1, 8'h90, 8'h3C, 8'h64, 2'd3);
    run_seq();
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    @(posedge clk); #1;
    serial = 1'b0;
    repeat (5) @(posedge clk); #1;
    serial = 1'b1;
    watch(12 * CPB);
    // reset in the data bits of 3C while dut0 still holds status 90
    b = 8'h3C;
    @(posedge clk); #1;
    serial = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (CPB) @(posedge clk); #1;
      serial = b[i];
    end
    repeat (CPB / 2) @(posedge clk); #1;
    rst_n  = 1'b0;
    serial = 1'b1;
    repeat (3) @(posedge clk);
    check_zero("reset_mid_byte");
    @(posedge clk); #1;
    rst_n = 1'b1;
    watch(12 * CPB);
    add(8'h3E, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h00, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h90, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h3C, 1'b1, 0, 0, 8'h00, 8'h00, 8'h00, 2'd0);
    add(8'h64, 1'b1, 1, 1, 8'h90, 8'h3C, 8'h64, 2'd3);
    run_seq();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_running_status();
    test_short_msgs();
    test_system_common();
    test_realtime();
    test_frame_err();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/midi_msg_rx.md
Name: midi_msg_rx

Overview:
- Parametrised MIDI receiver: UART byte deserialiser plus a MIDI message assembler.
- Converts the 31250-baud MIDI serial line into complete status/data messages.
- Supports running status, real-time byte passthrough and framing-error detection.
- Sits between the MIDI input pin and the synth voice/control logic.
- Replaces the fixed-timing, free-running byte grabber with a start/stop-aware, message-aligned receiver.

Parameters:
CLKS_PER_BIT, 1600, clk cycles per serial bit (50 MHz / 31250); must be >= 4.
SYNC_STAGES, 2, flops in the serial input synchroniser; must be >= 2.
RUNNING_STATUS, 1, 1 = channel status is retained for subsequent data bytes; 0 = every message needs an explicit status byte.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
serial  in  1  raw MIDI line, idle high, 8N1, LSB first
msg_status  out  8  status byte of the last completed message
msg_data1  out  8  first data byte (0 when msg_len == 1)
msg_data2  out  8  second data byte (0 when msg_len < 3)
msg_len  out  2  bytes in message, 1..3
msg_valid  out  1  one-cycle pulse; all msg_* outputs are valid in that cycle
rt_byte  out  8  last real-time byte (F8..FF)
rt_valid  out  1  one-cycle pulse with rt_byte
frame_err  out  1  one-cycle pulse when the stop bit samples low

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset values:
  - All outputs 0.
  - Synchroniser flops reset to 1 (idle).
  - Byte FSM enters IDLE; running status is cleared; byte count is 0.
- Reset mid-byte or mid-message discards the partial byte or message.
- The synchronised line, sr, is used everywhere. The bit counter is $clog2(CLKS_PER_BIT) bits wide.
- Byte FSM states:
  - IDLE: on sr == 0, go to START with cnt = 0.
  - START: at cnt == CLKS_PER_BIT/2-1, sample sr.
    - sr == 1: glitch, return to IDLE with no outputs.
    - sr == 0: go to DATA with cnt = 0, bit index = 0.
  - DATA: at cnt == CLKS_PER_BIT-1, shift sr into bit[index] (LSB first) and reset cnt. After bit 7, go to STOP.
  - STOP: at cnt == CLKS_PER_BIT-1, sample sr.
    - sr == 1: raise byte_done for one cycle, go to IDLE.
    - sr == 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for sr == 1, then go to IDLE. A held-low line therefore produces exactly one frame_err.
- Assembler, evaluated on byte_done with byte b:
  - F8..FF: rt_byte <= b, pulse rt_valid. Assembler state is untouched, so real-time bytes may be interleaved anywhere.
  - 80..EF: status <= b, data count = 0.
    - need = 1 for C0..DF.
    - need = 2 for 80..BF and E0..EF.
  - F1, F3: status <= b, need = 1.
  - F2: status <= b, need = 2.
  - F0, F4, F5, F6, F7: emit immediately with msg_len = 1, then clear status.
  - 00..7F with no status held: byte is discarded (this covers SysEx payload).
  - 00..7F with status held: store into data1, then data2.
    - When the count reaches need, emit msg_len = need+1 and reset the count to 0.
    - Status is kept for channel messages when RUNNING_STATUS = 1.
    - Status is cleared for system common messages, and for all messages when RUNNING_STATUS = 0.
  - A new status byte mid-message abandons the partial message without emitting it.
- Latency:
  - msg_valid and rt_valid assert exactly 1 clk after the stop-bit sample cycle.
  - frame_err asserts in the cycle after the stop-bit sample.
- msg_* and rt_byte hold their values until the next emit.
- msg_valid and rt_valid can never coincide, because both come from a single byte.

Test Plan:
All scenarios use CLKS_PER_BIT = 16.
- Bytes 90 3C 64 -> one msg_valid pulse with status 90, d1 3C, d2 64, len 3, 1 clk after the third stop sample.
- Bytes 90 3C 64 3E 00 with RUNNING_STATUS = 1 -> two pulses: (90,3C,64) then (90,3E,00). With RUNNING_STATUS = 0 -> the first pulse only.
- C5 07, then F6 -> (C5,07,00,len 2), then (F6,00,00,len 1).
- 90 3C F8 64 -> rt_valid with rt_byte F8 after the third byte, then msg (90,3C,64). No spurious msg_valid.
- A byte with the stop bit driven low, followed by 90 3C 64 -> exactly one frame_err pulse, no message, then a correct message.
- A low glitch of 5 clk, and separately rst_n asserted during the DATA bits of 3C -> no outputs. After reset, 90 3C 64 is received correctly.
